// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, default timing constants
// and the odd-parity helper used by both the transmit and receive paths.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StStart,
    StShift,
    StAck,
    StRecover
  } ps2_tx_state_e;

  localparam int unsigned DefInhibitCycles = 5000;
  localparam int unsigned DefTimeoutCycles = 750000;

  // Bits after the start bit: 8 data, parity, stop.
  localparam logic [3:0] LastFrameBit = 4'd10;

  // Parity bit that makes the count of ones over data plus parity odd.
  function automatic logic odd_parity(input logic [7:0] data);
    return ~(^data);
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a one-cycle
// strobe on each falling edge of the synchronized clock.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fall_o
);

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic data_meta_q, data_meta_d;
  logic data_sync_q, data_sync_d;

  always_comb begin
    clk_meta_d  = ps2_clk_i;
    clk_sync_d  = clk_meta_q;
    clk_prev_d  = clk_sync_q;
    data_meta_d = ps2_data_i;
    data_sync_d = data_meta_q;
  end

  // Idle PS/2 lines are high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      clk_prev_q  <= clk_prev_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
    end
  end

  assign clk_sync_o  = clk_sync_q;
  assign data_sync_o = data_sync_q;
  assign clk_fall_o  = clk_prev_q & ~clk_sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the clock, issues a start
// bit, shifts out data/parity/stop on device clock edges and checks the ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DefInhibitCycles,
  parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int unsigned CntMax =
      (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CntW = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);
  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutCnt  = CntW'(TIMEOUT_CYCLES);

  ps2_tx_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            clk_oe_q, clk_oe_d;
  logic            data_oe_q, data_oe_d;
  logic            done_q, done_d;
  logic            error_q, error_d;

  logic clk_s, data_s, clk_fall;

  ps2_sync_edge u_sync_edge (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk_i  (ps2_clk_in),
    .ps2_data_i (ps2_data_in),
    .clk_sync_o (clk_s),
    .data_sync_o(data_s),
    .clk_fall_o (clk_fall)
  );

  assign tx_ready = (state_q == StIdle);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    data_d    = data_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          data_d   = tx_data;
          cnt_d    = '0;
          bit_d    = '0;
          clk_oe_d = 1'b1;
          state_d  = StInhibit;
        end
      end
      StInhibit: begin
        if (cnt_q == InhibitLast) begin
          // Counter doubles as the watchdog from here on.
          cnt_d     = '0;
          bit_d     = '0;
          data_oe_d = 1'b1;
          state_d   = StStart;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StStart: begin
        clk_oe_d = 1'b0;
        cnt_d    = cnt_q + CntOne;
        state_d  = StShift;
      end
      StShift: begin
        cnt_d = cnt_q + CntOne;
        if (clk_fall) begin
          cnt_d = '0;
          if (bit_q < 4'd8) begin
            data_oe_d = ~data_q[bit_q[2:0]];
          end else if (bit_q == 4'd8) begin
            data_oe_d = ~odd_parity(data_q);
          end else begin
            data_oe_d = 1'b0;
            state_d   = StAck;
          end
          if (bit_q != LastFrameBit) begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      StAck: begin
        cnt_d = cnt_q + CntOne;
        if (clk_fall) begin
          cnt_d = '0;
          if (!data_s) begin
            state_d = StRecover;
          end else begin
            error_d = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRecover: begin
        cnt_d = cnt_q + CntOne;
        if (clk_fall) begin
          cnt_d = '0;
        end
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Watchdog yields to a transaction that is already finishing this cycle,
    // so done and error can never pulse together.
    if ((state_q inside {StStart, StShift, StAck, StRecover}) &&
        (cnt_d == TimeoutCnt) && (state_d != StIdle)) begin
      error_d   = 1'b1;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      cnt_d     = '0;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      data_q    <= data_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = ~tx_ready;
  assign tx_done     = done_q;
  assign tx_error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and each scenario compares the observed frame against one built from the byte.
module tb_ps2_host_tx;

  localparam int unsigned InhibitCycles = 10;
  localparam int unsigned TimeoutCycles = 200;
  localparam int unsigned HalfPeriod    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_error;
  logic       dev_clk_low, dev_data_low;
  logic       ps2_clk_in, ps2_data_in;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int err_seen = 0;
  int both_seen = 0;
  bit hold_valid = 1'b0;

  // Open-drain wired-AND bus shared by host and device.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(InhibitCycles),
    .TIMEOUT_CYCLES(TimeoutCycles)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe),
    .busy       (busy),
    .tx_done    (tx_done),
    .tx_error   (tx_error)
  );

  // Expected line value at device clock pulses 1..10 (index 0..9).
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic [9:0] f;
    for (int i = 0; i < 8; i++) f[i] = ((b >> i) & 8'd1) != 8'd0;
    f[8] = ($countones(b) % 2) == 0;
    f[9] = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(negedge clk);
    if (tx_done) done_seen++;
    if (tx_error) err_seen++;
    if (tx_done && tx_error) both_seen++;
    if (tx_done || tx_error) tx_valid = 1'b0;
    else if (hold_valid && tx_valid && busy) tx_data = 8'($urandom);
  endtask

  task automatic do_accept(input logic [7:0] b, output logic rdy_after);
    int n = 0;
    while (!tx_ready && n < 200) begin tick(); n++; end
    tx_data  = b;
    tx_valid = 1'b1;
    tick();
    rdy_after = tx_ready;
    if (!hold_valid) tx_valid = 1'b0;
  endtask

  task automatic wait_start(output int inh, output int st);
    inh = 0;
    while (ps2_clk_oe && !ps2_data_oe && inh < 100) begin inh++; tick(); end
    st = 0;
    while (ps2_clk_oe && ps2_data_oe && st < 10) begin st++; tick(); end
  endtask

  task automatic dev_pulse(output logic s);
    dev_clk_low = 1'b1;
    repeat (HalfPeriod) tick();
    s = ps2_data_in;
    dev_clk_low = 1'b0;
    repeat (HalfPeriod) tick();
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack, output logic rdy_after,
                           output int inh, output int st, output logic start_ok,
                           output logic [9:0] bits, output int done_n, output int err_n);
    int d0, e0, n;
    logic s;
    d0 = done_seen;
    e0 = err_seen;
    do_accept(b, rdy_after);
    wait_start(inh, st);
    repeat ($urandom_range(3, 20)) tick();
    start_ok = (ps2_data_in === 1'b0) && (ps2_clk_in === 1'b1);
    for (int k = 0; k < 10; k++) begin dev_pulse(s); bits[k] = s; end
    dev_data_low = ack;
    repeat (2) tick();
    dev_pulse(s);
    dev_data_low = 1'b0;
    n = 0;
    while (done_seen == d0 && err_seen == e0 && n < 100) begin tick(); n++; end
    repeat (2) tick();
    done_n = done_seen - d0;
    err_n  = err_seen - e0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #2;
    checks++;
    if ({tx_ready, busy, tx_done, tx_error} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_status: got %b expected 1000", {tx_ready, busy, tx_done, tx_error});
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin
      errors++;
      $display("FAIL reset_oe: got %b expected 00", {ps2_clk_oe, ps2_data_oe});
    end
    repeat (3) tick();
    rst = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_frame(input logic [7:0] b, input bit full);
    logic rdy, sok;
    logic [9:0] bits;
    int inh, st, dn, en;
    run_frame(b, 1'b1, rdy, inh, st, sok, bits, dn, en);
    if (full) begin
      checks++;
      if (rdy !== 1'b0) begin
        errors++;
        $display("FAIL accept_ready_drop %h: got %b expected 0", b, rdy);
      end
      checks++;
      if (inh != InhibitCycles || st != 1) begin
        errors++;
        $display("FAIL inhibit_len %h: got %0d/%0d expected %0d/1", b, inh, st, InhibitCycles);
      end
      checks++;
      if (sok !== 1'b1) begin
        errors++;
        $display("FAIL start_bit %h: got %b expected 1", b, sok);
      end
      checks++;
      if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
        errors++;
        $display("FAIL idle_after %h: got %b expected 1000", b,
                 {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
      end
    end
    checks++;
    if (bits !== exp_frame(b)) begin
      errors++;
      $display("FAIL frame_bits %h: got %b expected %b", b, bits, exp_frame(b));
    end
    checks++;
    if (dn != 1 || en != 0) begin
      errors++;
      $display("FAIL frame_result %h: got done=%0d err=%0d expected done=1 err=0", b, dn, en);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3; i++) test_frame(8'($urandom), 1'b0);
  endtask

  task automatic test_no_ack();
    logic rdy, sok;
    logic [9:0] bits;
    int inh, st, dn, en;
    logic [7:0] b;
    b = 8'($urandom);
    run_frame(b, 1'b0, rdy, inh, st, sok, bits, dn, en);
    checks++;
    if (bits !== exp_frame(b)) begin
      errors++;
      $display("FAIL noack_bits %h: got %b expected %b", b, bits, exp_frame(b));
    end
    checks++;
    if (dn != 0 || en != 1) begin
      errors++;
      $display("FAIL noack_result: got done=%0d err=%0d expected done=0 err=1", dn, en);
    end
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b001) begin
      errors++;
      $display("FAIL noack_lines: got %b expected 001", {ps2_clk_oe, ps2_data_oe, tx_ready});
    end
  endtask

  task automatic test_timeout();
    logic rdy;
    int inh, st, idx, d0, e0;
    logic oe_at_err;
    d0 = done_seen;
    e0 = err_seen;
    do_accept(8'hF4, rdy);
    wait_start(inh, st);
    idx = st;
    while (!tx_error && idx < 500) begin tick(); idx++; end
    oe_at_err = ps2_clk_oe | ps2_data_oe;
    repeat (5) tick();
    checks++;
    if (idx != TimeoutCycles) begin
      errors++;
      $display("FAIL timeout_latency: got %0d expected %0d", idx, TimeoutCycles);
    end
    checks++;
    if (oe_at_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_oe: got %b expected 0", oe_at_err);
    end
    checks++;
    if (err_seen - e0 != 1 || done_seen != d0) begin
      errors++;
      $display("FAIL timeout_pulses: got err=%0d done=%0d expected 1/0",
               err_seen - e0, done_seen - d0);
    end
  endtask

  task automatic test_reset_mid();
    logic rdy, s;
    int inh, st, d0, e0;
    do_accept(8'h3C, rdy);
    wait_start(inh, st);
    repeat (5) tick();
    for (int k = 0; k < 4; k++) dev_pulse(s);
    dev_clk_low = 1'b1;
    repeat (4) tick();
    d0 = done_seen;
    e0 = err_seen;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({ps2_clk_oe, ps2_data_oe, tx_done, tx_error, tx_ready, busy} !== 6'b000010) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected 000010",
               {ps2_clk_oe, ps2_data_oe, tx_done, tx_error, tx_ready, busy});
    end
    dev_clk_low = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (done_seen != d0 || err_seen != e0 || ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pulses: got done=%0d err=%0d clk_oe=%b expected 0/0/0",
               done_seen - d0, err_seen - e0, ps2_clk_oe);
    end
    test_frame(8'h55, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic rdy, sok;
    logic [9:0] bits;
    int inh, st, dn, en, extra;
    logic [7:0] b;
    b = 8'($urandom);
    hold_valid = 1'b1;
    run_frame(b, 1'b1, rdy, inh, st, sok, bits, dn, en);
    hold_valid = 1'b0;
    tx_valid = 1'b0;
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ps2_clk_oe || !tx_ready) extra++;
    end
    checks++;
    if (bits !== exp_frame(b)) begin
      errors++;
      $display("FAIL b2b_bits %h: got %b expected %b", b, bits, exp_frame(b));
    end
    checks++;
    if (dn != 1 || en != 0) begin
      errors++;
      $display("FAIL b2b_result: got done=%0d err=%0d expected 1/0", dn, en);
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL b2b_extra_txn: got %0d busy cycles expected 0", extra);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst          = 1'b1;
    tx_valid     = 1'b0;
    tx_data      = 8'h00;
    dev_clk_low  = 1'b0;
    dev_data_low = 1'b0;
    test_reset();
    test_frame(8'hED, 1'b1);
    test_frame(8'h01, 1'b1);
    test_random();
    test_no_ack();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    checks++;
    if (both_seen != 0) begin
      errors++;
      $display("FAIL done_error_overlap: got %0d expected 0", both_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, 5000, clk cycles ps2 clock is held low before start (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, 750000, max clk cycles between device falling edges (or from clock release to first edge).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port tx_valid  input  1  command byte offered.
REQ-006 SHALL have port tx_data  input  8  command byte to keyboard.
REQ-007 SHALL have port tx_ready  output  1  block idle, can accept a byte.
REQ-008 SHALL have port ps2_clk_in  input  1  raw PS/2 clock line, asynchronous.
REQ-009 SHALL have port ps2_data_in  input  1  raw PS/2 data line, asynchronous.
REQ-010 SHALL have port ps2_clk_oe  output  1  1 = drive PS/2 clock low, 0 = release (open drain).
REQ-011 SHALL have port ps2_data_oe  output  1  1 = drive PS/2 data low, 0 = release.
REQ-012 SHALL have port busy  output  1  transaction in progress; receiver ignores line while high.
REQ-013 SHALL have port tx_done  output  1  one-cycle pulse, device acknowledged byte.
REQ-014 SHALL have port tx_error  output  1  one-cycle pulse, no ack or timeout.

Function
REQ-015 SHALL accept a byte when tx_valid and tx_ready are both 1 on a rising edge; tx_data latched then; tx_ready drops next cycle; tx_valid ignored otherwise.
REQ-016 SHALL synchronize ps2_clk_in/ps2_data_in through two flops and detect falling edges of synchronized clock (one-cycle strobe).
REQ-017 SHALL implement states IDLE, INHIBIT, START, SHIFT, ACK, RECOVER.
REQ-018 IDLE: both oe 0, tx_ready 1, busy 0; on accept -> INHIBIT.
REQ-019 INHIBIT: ps2_clk_oe 1 for exactly INHIBIT_CYCLES cycles, data released -> START.
REQ-020 START: ps2_data_oe 1 and ps2_clk_oe 1 for one cycle, then ps2_clk_oe 0, data held low (start bit) -> SHIFT.
REQ-021 SHIFT: on falling edges 1..8 drive data bits 0..7 LSB first (oe = ~bit); edge 9 drives odd parity (ones in data+parity odd); edge 10 releases data (stop) -> ACK.
REQ-022 ACK: on next falling edge sample synchronized data; 0 -> RECOVER; 1 -> tx_error pulse, -> IDLE.
REQ-023 RECOVER: wait until synchronized clock and data both 1, then tx_done pulse, -> IDLE.
REQ-024 Watchdog counter SHALL clear on START entry and on every falling edge in SHIFT/ACK/RECOVER; reaching TIMEOUT_CYCLES -> tx_error pulse, both oe 0, -> IDLE.
REQ-025 tx_done and tx_error SHALL never assert in the same cycle; each asserts exactly once per transaction.
REQ-026 busy SHALL be 1 in every state except IDLE.
REQ-027 Bit counter SHALL be 4 bits, counting 0..10, cleared on START entry; no wrap beyond 10.

Reset
REQ-028 rst low SHALL immediately (asynchronously) force IDLE, ps2_clk_oe 0, ps2_data_oe 0, tx_ready 1, busy 0, tx_done 0, tx_error 0, counters 0, sync flops 1.
REQ-029 Reset mid-transaction SHALL release both lines with no done/error pulse; first accept after release starts a full new transaction.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the state enum typedef, default INHIBIT_CYCLES/TIMEOUT_CYCLES constants and a parity function shared with the receiver.
REQ-031 Sub-module ps2_sync_edge SHALL contain the two-flop synchronizers and falling-edge strobe, reusable by the receive driver.

Verification (bench params INHIBIT_CYCLES=10, TIMEOUT_CYCLES=200)
REQ-032 Send 0xED, device model clocks and acks -> clock held low 10 cycles, bits 1,0,1,1,0,1,1,1, parity 1, stop released, one tx_done pulse.
REQ-033 Send 0x01 -> parity bit 0 on edge 9; tx_done; tx_ready high again after line idle.
REQ-034 Device leaves data high at edge 11 -> one tx_error pulse, no tx_done, both oe 0.
REQ-035 Device never clocks after release -> tx_error exactly 200 cycles after START entry, both oe 0.
REQ-036 rst low at edge 5 of SHIFT -> oe both 0 same cycle, no pulses; subsequent send of 0x55 completes with tx_done.
REQ-037 tx_valid held high with new byte while busy -> ignored; only one transaction per accept.
